// File: rtl/load_result_unit.sv
// Tracks the single outstanding data-bus transaction and formats load return data for write-back.
// ld_valid rises one cycle after data_data_ok; the result is held while wb_stall is high.
module load_result_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  ld_addr_lo,
  input  logic [4:0]  ld_dest_in,
  input  logic [31:0] rt_old,
  input  logic        flush,
  input  logic        wb_stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [4:0]  ld_dest,
  output logic        ld_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [2:0] T_LB  = 3'b001;
  localparam logic [2:0] T_LBU = 3'b010;
  localparam logic [2:0] T_LH  = 3'b011;
  localparam logic [2:0] T_LHU = 3'b100;
  localparam logic [2:0] T_LWL = 3'b101;
  localparam logic [2:0] T_LWR = 3'b110;

  state_t      state;
  logic        tag_wr;
  logic [2:0]  tag_type;
  logic [1:0]  tag_lo;
  logic [4:0]  tag_dest;
  logic [31:0] tag_rt;

  logic        accept;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] fmt_data;

  assign accept = data_req & data_addr_ok;

  // Formatting uses the tag captured at accept, not the live request fields.
  always_comb begin
    sel_byte = data_rdata[7:0];
    case (tag_lo)
      2'd0: sel_byte = data_rdata[7:0];
      2'd1: sel_byte = data_rdata[15:8];
      2'd2: sel_byte = data_rdata[23:16];
      2'd3: sel_byte = data_rdata[31:24];
      default: sel_byte = data_rdata[7:0];
    endcase
    sel_half = tag_lo[1] ? data_rdata[31:16] : data_rdata[15:0];

    fmt_data = data_rdata;
    case (tag_type)
      T_LB:  fmt_data = {{24{sel_byte[7]}}, sel_byte};
      T_LBU: fmt_data = {24'h000000, sel_byte};
      T_LH:  fmt_data = {{16{sel_half[15]}}, sel_half};
      T_LHU: fmt_data = {16'h0000, sel_half};
      T_LWL: begin
        case (tag_lo)
          2'd0: fmt_data = {data_rdata[7:0],  tag_rt[23:0]};
          2'd1: fmt_data = {data_rdata[15:0], tag_rt[15:0]};
          2'd2: fmt_data = {data_rdata[23:0], tag_rt[7:0]};
          default: fmt_data = data_rdata;
        endcase
      end
      T_LWR: begin
        case (tag_lo)
          2'd1: fmt_data = {tag_rt[31:24], data_rdata[31:8]};
          2'd2: fmt_data = {tag_rt[31:16], data_rdata[31:16]};
          2'd3: fmt_data = {tag_rt[31:8],  data_rdata[31:24]};
          default: fmt_data = data_rdata;
        endcase
      end
      default: fmt_data = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ld_valid <= 1'b0;
      ld_busy  <= 1'b0;
      ld_data  <= 32'h0;
      ld_dest  <= 5'd0;
      tag_wr   <= 1'b0;
      tag_type <= 3'd0;
      tag_lo   <= 2'd0;
      tag_dest <= 5'd0;
      tag_rt   <= 32'h0;
    end else begin
      if (accept && (state == S_IDLE || state == S_HOLD)) begin
        tag_wr   <= data_wr;
        tag_type <= ld_type;
        tag_lo   <= ld_addr_lo;
        tag_dest <= ld_dest_in;
        tag_rt   <= rt_old;
      end

      case (state)
        S_IDLE: begin
          if (accept && flush) begin
            state    <= S_DROP;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b1;
          end else if (accept) begin
            state    <= S_PEND;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b1;
          end
        end
        S_PEND: begin
          // A flush coinciding with the return still consumes that return.
          if (flush && data_data_ok) begin
            state    <= S_IDLE;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b0;
          end else if (flush) begin
            state    <= S_DROP;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b1;
          end else if (data_data_ok && tag_wr) begin
            state    <= S_IDLE;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b0;
          end else if (data_data_ok) begin
            state    <= S_HOLD;
            ld_valid <= 1'b1;
            ld_busy  <= 1'b1;
            ld_data  <= fmt_data;
            ld_dest  <= tag_dest;
          end
        end
        S_HOLD: begin
          if (flush) begin
            state    <= S_IDLE;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b0;
          end else if (!wb_stall && accept) begin
            state    <= S_PEND;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b1;
          end else if (!wb_stall) begin
            state    <= S_IDLE;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b0;
          end
        end
        S_DROP: begin
          if (data_data_ok) begin
            state    <= S_IDLE;
            ld_valid <= 1'b0;
            ld_busy  <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          ld_valid <= 1'b0;
          ld_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_result_unit.sv
// Directed bench for load_result_unit: formatting, write completion, flush, stall hold, back-to-back.
module tb_load_result_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [2:0]  ld_type;
  logic [1:0]  ld_addr_lo;
  logic [4:0]  ld_dest_in;
  logic [31:0] rt_old;
  logic        flush, wb_stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [4:0]  ld_dest;
  logic        ld_busy;

  int checks = 0;
  int errors = 0;

  load_result_unit dut (
    .clk(clk), .rst(rst),
    .data_req(data_req), .data_wr(data_wr), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ld_type(ld_type), .ld_addr_lo(ld_addr_lo), .ld_dest_in(ld_dest_in),
    .rt_old(rt_old), .flush(flush), .wb_stall(wb_stall),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_dest(ld_dest), .ld_busy(ld_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepts one load, returns data `gap` cycles after the accept cycle, and stops right after the return edge.
  task automatic do_load(input logic [2:0] t, input logic [1:0] lo, input logic [4:0] d,
                         input logic [31:0] rt, input logic [31:0] rd, input int gap);
    data_req = 1'b1; data_addr_ok = 1'b1; data_wr = 1'b0;
    ld_type = t; ld_addr_lo = lo; ld_dest_in = d; rt_old = rt;
    step();
    data_req = 1'b0; data_addr_ok = 1'b0;
    ld_type = 3'd0; ld_addr_lo = 2'd0; ld_dest_in = 5'd0; rt_old = 32'h0;
    for (int i = 1; i < gap; i++) step();
    data_data_ok = 1'b1; data_rdata = rd;
    step();
    data_data_ok = 1'b0; data_rdata = 32'hDEADDEAD;
  endtask

  initial begin
    rst = 1'b1; data_req = 1'b0; data_wr = 1'b0; data_addr_ok = 1'b0;
    data_data_ok = 1'b0; data_rdata = 32'h0; ld_type = 3'd0; ld_addr_lo = 2'd0;
    ld_dest_in = 5'd0; rt_old = 32'h0; flush = 1'b0; wb_stall = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, ld_valid}, 32'd0);
    chk("rst_data",  ld_data, 32'h0);
    chk("rst_dest",  {27'd0, ld_dest}, 32'd0);
    chk("rst_busy",  {31'd0, ld_busy}, 32'd0);

    // LB sign-extend, data_ok 3 cycles after accept
    data_req = 1'b1; data_addr_ok = 1'b1; ld_type = 3'b001; ld_addr_lo = 2'd2; ld_dest_in = 5'd7;
    step();
    data_req = 1'b0; data_addr_ok = 1'b0; ld_type = 3'd0; ld_addr_lo = 2'd0; ld_dest_in = 5'd0;
    chk("lb_pend_busy",  {31'd0, ld_busy}, 32'd1);
    chk("lb_pend_valid", {31'd0, ld_valid}, 32'd0);
    step(); step();
    data_data_ok = 1'b1; data_rdata = 32'h12803456;
    step();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    chk("lb_valid", {31'd0, ld_valid}, 32'd1);
    chk("lb_data",  ld_data, 32'hFFFFFF80);
    chk("lb_dest",  {27'd0, ld_dest}, 32'd7);
    step();
    chk("lb_consumed_valid", {31'd0, ld_valid}, 32'd0);
    chk("lb_consumed_busy",  {31'd0, ld_busy}, 32'd0);
    chk("lb_data_kept",      ld_data, 32'hFFFFFF80);

    do_load(3'b100, 2'd2, 5'd3, 32'h0, 32'hBEEF1234, 1);
    chk("lhu_data", ld_data, 32'h0000BEEF);
    chk("lhu_dest", {27'd0, ld_dest}, 32'd3);
    step();
    do_load(3'b011, 2'd3, 5'd4, 32'h0, 32'hBEEF1234, 1);
    chk("lh_data", ld_data, 32'hFFFFBEEF);
    step();
    do_load(3'b101, 2'd1, 5'd5, 32'hAABBCCDD, 32'h11223344, 2);
    chk("lwl1_data", ld_data, 32'h3344CCDD);
    step();
    do_load(3'b110, 2'd1, 5'd6, 32'hAABBCCDD, 32'h11223344, 2);
    chk("lwr1_data", ld_data, 32'hAA112233);
    step();
    do_load(3'b101, 2'd0, 5'd6, 32'hAABBCCDD, 32'h11223344, 1);
    chk("lwl0_data", ld_data, 32'h44BBCCDD);
    step();
    do_load(3'b110, 2'd3, 5'd6, 32'hAABBCCDD, 32'h11223344, 1);
    chk("lwr3_data", ld_data, 32'hAABBCC11);
    step();
    do_load(3'b010, 2'd3, 5'd8, 32'h0, 32'h80FFFFFF, 1);
    chk("lbu3_data", ld_data, 32'h00000080);
    step();
    do_load(3'b111, 2'd2, 5'd9, 32'h0, 32'hCAFEF00D, 1);
    chk("lw7_data", ld_data, 32'hCAFEF00D);
    step();

    // Write completion: no result, busy only while pending
    data_req = 1'b1; data_addr_ok = 1'b1; data_wr = 1'b1; ld_dest_in = 5'd11;
    step();
    data_req = 1'b0; data_addr_ok = 1'b0; data_wr = 1'b0; ld_dest_in = 5'd0;
    chk("wr_busy1",  {31'd0, ld_busy}, 32'd1);
    chk("wr_valid1", {31'd0, ld_valid}, 32'd0);
    step();
    chk("wr_busy2",  {31'd0, ld_busy}, 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h55555555;
    step();
    data_data_ok = 1'b0;
    chk("wr_done_valid", {31'd0, ld_valid}, 32'd0);
    chk("wr_done_busy",  {31'd0, ld_busy}, 32'd0);
    chk("wr_data_kept",  ld_data, 32'hCAFEF00D);

    // Flush while pending, data_ok two cycles later
    data_req = 1'b1; data_addr_ok = 1'b1; ld_type = 3'b000; ld_dest_in = 5'd12;
    step();
    data_req = 1'b0; data_addr_ok = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_pend_busy",  {31'd0, ld_busy}, 32'd1);
    chk("fl_pend_valid", {31'd0, ld_valid}, 32'd0);
    step();
    data_data_ok = 1'b1; data_rdata = 32'h77777777;
    step();
    data_data_ok = 1'b0;
    chk("fl_pend_done_valid", {31'd0, ld_valid}, 32'd0);
    chk("fl_pend_done_busy",  {31'd0, ld_busy}, 32'd0);
    step();
    chk("fl_pend_after_valid", {31'd0, ld_valid}, 32'd0);

    // Flush coincident with accept
    data_req = 1'b1; data_addr_ok = 1'b1; flush = 1'b1;
    step();
    data_req = 1'b0; data_addr_ok = 1'b0; flush = 1'b0;
    chk("fl_acc_busy",  {31'd0, ld_busy}, 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h88888888;
    step();
    data_data_ok = 1'b0;
    chk("fl_acc_valid", {31'd0, ld_valid}, 32'd0);
    chk("fl_acc_busy2", {31'd0, ld_busy}, 32'd0);
    chk("fl_acc_data",  ld_data, 32'hCAFEF00D);

    // Flush while holding a result
    wb_stall = 1'b1;
    do_load(3'b000, 2'd0, 5'd13, 32'h0, 32'h01020304, 1);
    chk("fl_hold_valid", {31'd0, ld_valid}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_hold_gone",  {31'd0, ld_valid}, 32'd0);
    chk("fl_hold_busy",  {31'd0, ld_busy}, 32'd0);

    // Stall hold for 4 cycles, then release with a back-to-back accept
    do_load(3'b001, 2'd1, 5'd14, 32'h0, 32'h0000FE00, 2);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", {31'd0, ld_valid}, 32'd1);
      chk("stall_data",  ld_data, 32'hFFFFFFFE);
      chk("stall_dest",  {27'd0, ld_dest}, 32'd14);
      if (i < 3) step();
    end
    wb_stall = 1'b0;
    data_req = 1'b1; data_addr_ok = 1'b1; ld_type = 3'b010; ld_addr_lo = 2'd0; ld_dest_in = 5'd15;
    step();
    data_req = 1'b0; data_addr_ok = 1'b0; ld_type = 3'd0; ld_dest_in = 5'd0;
    chk("b2b_valid", {31'd0, ld_valid}, 32'd0);
    chk("b2b_busy",  {31'd0, ld_busy}, 32'd1);
    data_data_ok = 1'b1; data_rdata = 32'h123456F0;
    step();
    data_data_ok = 1'b0;
    chk("b2b_res_valid", {31'd0, ld_valid}, 32'd1);
    chk("b2b_res_data",  ld_data, 32'h000000F0);
    chk("b2b_res_dest",  {27'd0, ld_dest}, 32'd15);
    step();
    chk("b2b_idle", {31'd0, ld_busy}, 32'd0);

    // Reset mid-transaction abandons it
    data_req = 1'b1; data_addr_ok = 1'b1; ld_dest_in = 5'd16;
    step();
    data_req = 1'b0; data_addr_ok = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_mid_data", ld_data, 32'h0);
    data_data_ok = 1'b1; data_rdata = 32'h99999999;
    step();
    data_data_ok = 1'b0;
    chk("rst_mid_valid", {31'd0, ld_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_result_unit.md
# load_result_unit

- Sits directly downstream of the MEM-stage data SRAM bridge.
- Tracks the single outstanding data-bus transaction from address acceptance to data return.
- For loads, captures `data_rdata`, extracts and extends it per the load type and address offset (LB/LBU/LH/LHU/LW/LWL/LWR), and holds the result for the write-back stage.
- Discards return data for transactions cancelled by a pipeline flush.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `data_req`  in  1  bus request, from the bridge
- `data_wr`  in  1  request is a write
- `data_addr_ok`  in  1  bus accepted address
- `data_data_ok`  in  1  bus returned data / write completion
- `data_rdata`  in  32  bus read data, word-aligned, little-endian lanes
- `ld_type`  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWL, 110 LWR, 111 treated as LW
- `ld_addr_lo`  in  2  byte offset addr[1:0] of the access
- `ld_dest_in`  in  5  destination GPR number
- `rt_old`  in  32  current rt value, used for LWL/LWR merge
- `flush`  in  1  cancel the outstanding or held transaction
- `wb_stall`  in  1  write-back cannot consume this cycle
- `ld_valid`  out  1  `ld_data`/`ld_dest` hold a completed load
- `ld_data`  out  32  formatted load result
- `ld_dest`  out  5  destination GPR
- `ld_busy`  out  1  a transaction is pending or a result is held

## Operation
- **Accept:** accept = `data_req & data_addr_ok`.
  - On accept, latch `data_wr`, `ld_type`, `ld_addr_lo`, `ld_dest_in`, `rt_old` into the tag registers.
  - At most one transaction is outstanding.
- **States:** IDLE, PEND, HOLD, DROP.
- **IDLE:**
  - accept & flush → DROP.
  - accept → PEND.
  - `data_data_ok` is ignored.
- **PEND:**
  - flush → DROP; any `data_data_ok` in the same cycle is still consumed, so the next state is IDLE.
  - `data_data_ok` & tagged write → IDLE.
  - `data_data_ok` & tagged load → HOLD; register the formatted data and the tag dest.
- **HOLD:**
  - flush → IDLE.
  - `~wb_stall` & accept → PEND; the result is consumed this cycle.
  - `~wb_stall` → IDLE.
  - otherwise stay in HOLD.
  - accept while `wb_stall` = 1 is a protocol error; the upstream stall prevents it.
- **DROP:** `data_data_ok` → IDLE, no output. A second accept is not possible.
- **Formatting** (computed from the tag at capture):
  - Let `b` be the byte at `rdata[8*lo+7 : 8*lo]`.
  - LB: sign-extend `b`. LBU: zero-extend `b`.
  - LH/LHU: half selected by `lo[1]`, sign- or zero-extended; `lo[0]` is ignored (alignment faults are raised upstream).
  - LWL, by `lo`:
    - 0: `{rdata[7:0], rt[23:0]}`
    - 1: `{rdata[15:0], rt[15:0]}`
    - 2: `{rdata[23:0], rt[7:0]}`
    - 3: `rdata`
  - LWR, by `lo`:
    - 0: `rdata`
    - 1: `{rt[31:24], rdata[31:8]}`
    - 2: `{rt[31:16], rdata[31:16]}`
    - 3: `{rt[31:8], rdata[31:24]}`
- **Outputs:**
  - `ld_valid` = (state == HOLD).
  - `ld_busy` = (state != IDLE).
  - `ld_data`/`ld_dest` keep their last value outside HOLD.

## Timing
- **Reset:** state IDLE, `ld_valid` 0, `ld_data` 0x00000000, `ld_dest` 0, `ld_busy` 0, tag registers 0. Reset mid-transaction abandons it; no output follows.
- **Latency:** `ld_valid` rises exactly one cycle after the `data_data_ok` cycle.
- **Earliest return:** `data_data_ok` arrives one cycle after accept at the earliest.
- **Hold:** `ld_valid` stays high while `wb_stall` = 1 and falls the cycle after a cycle with `wb_stall` = 0 or `flush` = 1.
- **Back-to-back:** accept in the consume cycle gives `ld_valid` = 0 the next cycle, with PEND entered.
- **Flush:** flush is effective in the same cycle. No `ld_valid` is produced for any transaction accepted at or before that cycle.

## Test plan
- **LB sign-extend:** LB, `lo` = 2, `rdata` = 0x12_80_34_56, data_ok 3 cycles after accept → `ld_valid` one cycle later, `ld_data` = 0xFFFFFF80, `ld_dest` = tag.
- **LHU / LH upper half:** LHU, `lo` = 2, `rdata` = 0xBEEF1234 → 0x0000BEEF. LH, same inputs → 0xFFFFBEEF.
- **LWL/LWR merge:** `rt_old` = 0xAABBCCDD, `rdata` = 0x11223344.
  - LWL `lo` = 1 → 0x3344CCDD.
  - LWR `lo` = 1 → 0xAA112233.
- **Write completion:** write accept, then data_ok → `ld_valid` never asserts; `ld_busy` 1 for the PEND cycles, then 0.
- **Flush cases:**
  - flush in PEND, then data_ok 2 cycles later → no `ld_valid`; state returns to IDLE.
  - flush coincident with accept → same result.
- **Stall hold and back-to-back:**
  - `wb_stall` = 1 for 4 cycles in HOLD → `ld_valid`/`ld_data` stable for all 4.
  - Release with a new accept in the same cycle → `ld_valid` 0 next cycle; the second result appears one cycle after its data_ok.
